// File: rtl/mux_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mux_share_arbiter
// Purpose  : Round-robin owner of a shared registered mux with dead-time switch
// Revision : 1.0
// ============================================================================
module mux_share_arbiter #(
  parameter int NREQ     = 4,
  parameter int W        = 8,
  parameter int MAX_HOLD = 8,
  parameter int DEAD     = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*W-1:0]        data_in,
  output logic [NREQ-1:0]          grant,
  output logic [$clog2(NREQ)-1:0]  sel,
  output logic                     out_valid,
  output logic [W-1:0]             out_data,
  output logic                     busy
);

  localparam int SW = $clog2(NREQ);
  localparam int HW = $clog2(MAX_HOLD + 1);
  localparam logic [HW-1:0] HOLD_MAX  = HW'(MAX_HOLD);
  localparam logic [1:0]    DEAD_LAST = 2'((DEAD == 0) ? 0 : DEAD - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    SWITCH = 2'd2
  } state_t;

  state_t          state_q;
  logic [NREQ-1:0] grant_q;
  logic [SW-1:0]   sel_q;
  logic [SW-1:0]   last_q;
  logic            out_valid_q;
  logic [W-1:0]    out_data_q;
  logic [HW-1:0]   hold_cnt_q;
  logic [1:0]      dead_cnt_q;

  logic [SW-1:0]   cand;
  logic [SW-1:0]   pick_idx;
  logic            pick_valid;
  logic            others;
  logic            leave;
  logic            dead_done;
  logic            grant_now;
  logic [W-1:0]    owner_data;

  // Scan from farthest to nearest so the candidate right after last_q wins.
  always_comb begin
    cand       = '0;
    pick_idx   = '0;
    pick_valid = 1'b0;
    for (int k = NREQ; k >= 1; k--) begin
      cand = SW'((int'(last_q) + k) % NREQ);
      if (req[cand]) begin
        pick_valid = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  assign owner_data = data_in[sel_q*W +: W];
  assign others     = |(req & ~grant_q);
  assign leave      = (state_q == HOLD) &&
                      (!req[sel_q] || ((hold_cnt_q == HOLD_MAX) && others));
  assign dead_done  = (state_q == SWITCH) && (dead_cnt_q == DEAD_LAST);
  // With no dead time a release hands over directly on the same edge.
  assign grant_now  = pick_valid &&
                      ((state_q == IDLE) || dead_done || (leave && (DEAD == 0)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      sel_q       <= '0;
      last_q      <= SW'(NREQ - 1);
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      hold_cnt_q  <= '0;
      dead_cnt_q  <= '0;
    end else begin
      case (state_q)
        IDLE: ;
        HOLD: begin
          if (leave) begin
            grant_q     <= '0;
            out_valid_q <= 1'b0;
            if (DEAD == 0) begin
              state_q <= IDLE;
            end else begin
              state_q    <= SWITCH;
              dead_cnt_q <= '0;
            end
          end else begin
            out_data_q  <= owner_data;
            out_valid_q <= 1'b1;
            if (hold_cnt_q != HOLD_MAX) hold_cnt_q <= hold_cnt_q + 1'b1;
          end
        end
        SWITCH: begin
          if (dead_done) state_q <= IDLE;
          else           dead_cnt_q <= dead_cnt_q + 1'b1;
        end
        default: state_q <= IDLE;
      endcase

      if (grant_now) begin
        grant_q    <= NREQ'(1) << pick_idx;
        sel_q      <= pick_idx;
        last_q     <= pick_idx;
        hold_cnt_q <= HW'(1);
        state_q    <= HOLD;
      end
    end
  end

  assign grant     = grant_q;
  assign sel       = sel_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign busy      = (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mux_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mux_share_arbiter
// Purpose  : Directed vector bench for mux_share_arbiter (DEAD=1 and DEAD=0)
// Revision : 1.0
// ============================================================================
module tb_mux_share_arbiter;

  typedef struct {
    logic [3:0] req;
    logic [3:0] grant;
    logic [1:0] sel;
    logic       valid;
    logic [7:0] data;
    logic       busy;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_a_n, rst_b_n;
  logic [3:0]  req_a, req_b;
  logic [31:0] data_in = 32'hD3C2B1A0;
  logic [3:0]  grant_a, grant_b;
  logic [1:0]  sel_a, sel_b;
  logic        valid_a, valid_b, busy_a, busy_b;
  logic [7:0]  data_a, data_b;

  int n_cmp = 0;
  int n_err = 0;

  vec_t tbl_a[16];
  vec_t tbl_b[7];

  always #5 clk = ~clk;

  mux_share_arbiter #(.NREQ(4), .W(8), .MAX_HOLD(8), .DEAD(1)) u_dut_a (
    .clk(clk), .rst_n(rst_a_n), .req(req_a), .data_in(data_in),
    .grant(grant_a), .sel(sel_a), .out_valid(valid_a), .out_data(data_a), .busy(busy_a)
  );

  mux_share_arbiter #(.NREQ(4), .W(8), .MAX_HOLD(2), .DEAD(0)) u_dut_b (
    .clk(clk), .rst_n(rst_b_n), .req(req_b), .data_in(data_in),
    .grant(grant_b), .sel(sel_b), .out_valid(valid_b), .out_data(data_b), .busy(busy_b)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_a(input string nm, input vec_t v);
    chk({nm, ".grant"}, 32'(grant_a), 32'(v.grant));
    chk({nm, ".sel"},   32'(sel_a),   32'(v.sel));
    chk({nm, ".valid"}, 32'(valid_a), 32'(v.valid));
    chk({nm, ".data"},  32'(data_a),  32'(v.data));
    chk({nm, ".busy"},  32'(busy_a),  32'(v.busy));
  endtask

  task automatic chk_b(input string nm, input vec_t v);
    chk({nm, ".grant"}, 32'(grant_b), 32'(v.grant));
    chk({nm, ".sel"},   32'(sel_b),   32'(v.sel));
    chk({nm, ".valid"}, 32'(valid_b), 32'(v.valid));
    chk({nm, ".data"},  32'(data_b),  32'(v.data));
    chk({nm, ".busy"},  32'(busy_b),  32'(v.busy));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] oh;
    logic [7:0] dsel;
    int owners[5];
    owners = '{0, 1, 2, 3, 0};

    //              req      grant    sel  v  data   busy
    tbl_a[0]  = '{4'b0100, 4'b0100, 2'd2, 0, 8'h00, 1};
    tbl_a[1]  = '{4'b0100, 4'b0100, 2'd2, 1, 8'hC2, 1};
    tbl_a[2]  = '{4'b0000, 4'b0000, 2'd2, 0, 8'hC2, 1};
    tbl_a[3]  = '{4'b0000, 4'b0000, 2'd2, 0, 8'hC2, 0};
    tbl_a[4]  = '{4'b0010, 4'b0010, 2'd1, 0, 8'hC2, 1};
    tbl_a[5]  = '{4'b1010, 4'b0010, 2'd1, 1, 8'hB1, 1};
    tbl_a[6]  = '{4'b1010, 4'b0010, 2'd1, 1, 8'hB1, 1};
    tbl_a[7]  = '{4'b1010, 4'b0010, 2'd1, 1, 8'hB1, 1};
    tbl_a[8]  = '{4'b1000, 4'b0000, 2'd1, 0, 8'hB1, 1};
    tbl_a[9]  = '{4'b1000, 4'b1000, 2'd3, 0, 8'hB1, 1};
    tbl_a[10] = '{4'b1000, 4'b1000, 2'd3, 1, 8'hD3, 1};
    tbl_a[11] = '{4'b0001, 4'b0000, 2'd3, 0, 8'hD3, 1};
    tbl_a[12] = '{4'b0001, 4'b0001, 2'd0, 0, 8'hD3, 1};
    tbl_a[13] = '{4'b0001, 4'b0001, 2'd0, 1, 8'hA0, 1};
    tbl_a[14] = '{4'b0000, 4'b0000, 2'd0, 0, 8'hA0, 1};
    tbl_a[15] = '{4'b0000, 4'b0000, 2'd0, 0, 8'hA0, 0};

    tbl_b[0]  = '{4'b0001, 4'b0001, 2'd0, 0, 8'h00, 1};
    tbl_b[1]  = '{4'b0001, 4'b0001, 2'd0, 1, 8'hA0, 1};
    tbl_b[2]  = '{4'b0010, 4'b0010, 2'd1, 0, 8'hA0, 1};
    tbl_b[3]  = '{4'b0011, 4'b0010, 2'd1, 1, 8'hB1, 1};
    tbl_b[4]  = '{4'b0011, 4'b0001, 2'd0, 0, 8'hB1, 1};
    tbl_b[5]  = '{4'b0011, 4'b0001, 2'd0, 1, 8'hA0, 1};
    tbl_b[6]  = '{4'b0011, 4'b0010, 2'd1, 0, 8'hA0, 1};

    rst_a_n = 1'b0;
    rst_b_n = 1'b0;
    req_a   = '0;
    req_b   = '0;
    #2;
    chk_a("reset_a", '{4'b0000, 4'b0000, 2'd0, 0, 8'h00, 0});
    tick();
    tick();
    rst_a_n = 1'b1;
    rst_b_n = 1'b1;

    // Basic grant latency, release with dead cycle, round-robin order.
    for (int i = 0; i < 16; i++) begin
      req_a = tbl_a[i].req;
      tick();
      chk_a($sformatf("vec_a%0d", i), tbl_a[i]);
    end

    // Lone requester is never preempted.
    req_a = 4'b0001;
    tick();
    chk_a("lone_first", '{4'b0001, 4'b0001, 2'd0, 0, 8'hA0, 1});
    for (int c = 0; c < 20; c++) begin
      tick();
      chk_a($sformatf("lone%0d", c), '{4'b0001, 4'b0001, 2'd0, 1, 8'hA0, 1});
    end
    req_a = 4'b0000;
    tick();
    tick();
    chk("lone_idle", 32'(busy_a), 32'd0);

    // Full contention: each owner holds MAX_HOLD cycles, one dead cycle between.
    rst_a_n = 1'b0;
    tick();
    rst_a_n = 1'b1;
    req_a   = 4'b1111;
    for (int o = 0; o < 5; o++) begin
      oh = 4'b0001 << owners[o];
      dsel = 8'(data_in >> (8 * owners[o]));
      for (int c = 0; c < 8; c++) begin
        tick();
        chk($sformatf("rr%0d_grant%0d", o, c), 32'(grant_a), 32'(oh));
        chk($sformatf("rr%0d_valid%0d", o, c), 32'(valid_a), (c == 0) ? 32'd0 : 32'd1);
        if (c != 0) chk($sformatf("rr%0d_data%0d", o, c), 32'(data_a), 32'(dsel));
      end
      if (o != 4) begin
        tick();
        chk($sformatf("rr%0d_dead", o), 32'(grant_a), 32'd0);
        chk($sformatf("rr%0d_deadv", o), 32'(valid_a), 32'd0);
      end
    end

    // Asynchronous reset in the middle of a hold.
    #2;
    rst_a_n = 1'b0;
    #1;
    chk_a("async_rst", '{4'b0000, 4'b0000, 2'd0, 0, 8'h00, 0});
    req_a = 4'b1010;
    #2;
    rst_a_n = 1'b1;
    tick();
    chk_a("post_rst", '{4'b1010, 4'b0010, 2'd1, 0, 8'h00, 1});

    // Zero dead time: direct handover on release and on preemption.
    for (int i = 0; i < 7; i++) begin
      req_b = tbl_b[i].req;
      tick();
      chk_b($sformatf("vec_b%0d", i), tbl_b[i]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Grant must never be multi-hot on either instance.
  always @(negedge clk) begin
    if (rst_a_n && rst_b_n) begin
      chk("onehot_a", 32'($onehot0(grant_a)), 32'd1);
      chk("onehot_b", 32'($onehot0(grant_b)), 32'd1);
    end
  end

endmodule
`default_nettype wire
